muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, in parallel with the ALU.
- Takes the same forwarded rs1/rs2 operands as the ALU and drives the EX-stage result mux that feeds EX/MEM.
- Multi-cycle: the hazard unit stalls the pipeline while busy is high.
- Radix-2 shift-add multiply and restoring divide, one bit per clock.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; the shift counter is $clog2(WIDTH) bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- flush  in  1  pipeline kill; abandons any operation in flight.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  WIDTH  rs1 operand.
- b  in  WIDTH  rs2 operand.
- busy  out  1  high in CALC and DONE; drives the stall.
- valid  out  1  one-cycle pulse, result valid.
- result  out  WIDTH  registered result.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high, on ports clk and reset.
- Reset values: state=IDLE, busy=0, valid=0, result=0, counter=0, all internal registers 0. Reset mid-operation aborts with no valid pulse.
- States:
  - IDLE -> CALC on start & !flush. Edge k latches op, operand magnitudes and sign flags; counter=0.
  - IDLE -> DONE directly, same edge, for the special divide cases below (fast path).
  - CALC -> DONE after 32 iterations (counter wraps 31->0).
  - DONE -> IDLE unconditionally.
- Latency, with start asserted in cycle C:
  - Normal ops: valid in cycle C+33; busy high C+1..C+33.
  - Fast path: valid in cycle C+1.
- valid is high exactly while in DONE. result updates on entry to DONE and holds until the next DONE.
- start outside IDLE is ignored. No queueing.
- flush in any state -> IDLE at the next edge; valid and busy low from then on. flush with start in IDLE: flush wins, nothing accepted. flush in DONE: valid still seen that cycle; the consumer qualifies it.
- Signs:
  - a is treated as signed for MULH, MULHSU, DIV, REM.
  - b is treated as signed for MULH, DIV, REM.
  - Operands are converted to magnitudes for the unsigned core.
- Multiply: 64-bit unsigned product is built over 32 shift-add steps and negated if sa^sb. MUL returns bits[31:0]; MULH, MULHSU, MULHU return bits[63:32].
- Divide: restoring, 32 steps, with a 33-bit partial remainder. Quotient is negated if sa^sb (signed ops). Remainder takes the sign of the dividend.
- Fast path, divide by zero (b==0): DIV/DIVU result=0xFFFFFFFF; REM/REMU result=a.
- Fast path, signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- Operands a, b and op may change after the start edge without affecting the result.

Decomposition:
- muldiv_pkg:
  - op_t enum of the 8 funct3 codes.
  - state_t enum {IDLE, CALC, DONE}.
  - Constants DIV_ZERO_Q = '1 and INT_MIN = 32'h8000_0000.
  - Helper functions is_div(op) and is_signed_a/b(op).
- muldiv_unit owns the FSM, sign pre-processing, fast path and post-negation.
- One sub-module, muldiv_core: the unsigned 64-bit shift datapath (accumulator/remainder, multiplier/quotient register) doing one mul or div step per enabled cycle, plus the counter.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (start at C) -> busy C+1..C+33; valid only at C+33; result=0xFFFFFFEB.
- MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF. MULH with the same operands -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast path:
  - DIVU 5/0 -> valid at C+1, result=0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- flush at C+10 of a DIV -> no valid pulse; busy low at C+11. A new start at C+11 is accepted and completes correctly. start pulsed at C+5 while busy is ignored, no second result.
- reset asserted at C+20 of a MUL -> next cycle busy=0, valid=0, result=0. Back-to-back start the cycle after DONE is accepted.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types, constants and opcode-decoding helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] DIV_ZERO_Q = '1;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic is_div(input op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input op_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(input op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned shift datapath: one shift-add multiply or restoring divide step per enabled cycle.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             div_op,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    // hi: product high half / partial remainder; lo: multiplier then product low / quotient.
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic             div_mode;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   partial;
    logic             fits;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        partial = {hi, lo[WIDTH-1]};
        fits    = (partial >= {1'b0, opnd});
        if (div_mode) begin
            // The partial remainder stays below the divisor, so the difference fits WIDTH bits.
            hi_next = fits ? (partial[WIDTH-1:0] - opnd) : partial[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            hi       <= '0;
            lo       <= mag_a;
            opnd     <= mag_b;
            div_mode <= div_op;
            cnt      <= '0;
        end else if (step) begin
            hi       <= hi_next;
            lo       <= lo_next;
            cnt      <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling, divide fast path and result fix-up.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    state_t state;
    op_t    op_q;
    logic   neg_q;
    logic   neg_r;

    op_t              op_in;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             div_ovf;
    logic             fast;
    logic [WIDTH-1:0] fast_res;
    logic             accept;

    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;
    logic               last;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   final_res;

    assign op_in    = op_t'(op);
    assign sign_a   = is_signed_a(op_in) & a[WIDTH-1];
    assign sign_b   = is_signed_b(op_in) & b[WIDTH-1];
    assign mag_a    = sign_a ? -a : a;
    assign mag_b    = sign_b ? -b : b;
    assign div_zero = (b == '0);
    assign div_ovf  = is_signed_b(op_in) && (a == INT_MIN) && (b == '1);
    assign fast     = is_div(op_in) & (div_zero | div_ovf);
    assign accept   = (state == IDLE) & start & ~flush;

    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = is_rem(op_in) ? a : DIV_ZERO_Q;
        else
            fast_res = is_rem(op_in) ? '0 : INT_MIN;
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (accept & ~fast),
        .step    ((state == CALC) & ~flush),
        .div_op  (is_div(op_in)),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .hi_next (hi_next),
        .lo_next (lo_next),
        .last    (last)
    );

    // Result is taken from the core's final step so it is registered on the same edge as DONE.
    always_comb begin
        prod      = neg_q ? -{hi_next, lo_next} : {hi_next, lo_next};
        quo       = neg_q ? -lo_next : lo_next;
        rem       = neg_r ? -hi_next : hi_next;
        final_res = '0;
        case (op_q)
            OP_MUL:                       final_res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              final_res = quo;
            default:                      final_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= OP_MUL;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (fast) begin
                            state  <= DONE;
                            valid  <= 1'b1;
                            result <= fast_res;
                        end else begin
                            state <= CALC;
                            op_q  <= op_in;
                            neg_q <= sign_a ^ sign_b;
                            neg_r <= sign_a;
                        end
                    end
                end
                CALC: begin
                    if (last) begin
                        state  <= DONE;
                        valid  <= 1'b1;
                        result <= final_res;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, monitor pops on valid.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] prev_res = '0;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;
    exp_t sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference model straight from the RV32M rules, using native 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      ux = longint'({32'b0, x});
        longint      p;
        logic [63:0] pu;
        int          qi;
        case (o)
            3'd0: begin pu = {32'b0, x} * {32'b0, y}; return pu[31:0];  end
            3'd1: begin p = sx * sy;                  return p[63:32];  end
            3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
            3'd3: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                qi = $signed(x) / $signed(y);
                return qi;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                qi = $signed(x) % $signed(y);
                return qi;
            end
            default: return (y == 0) ? x : (ux % longint'({32'b0, y}));
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o >= 3'd4 && (y == 0 || ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Issues one operation; returns in the DONE cycle so the next call starts back-to-back.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit now);
        int          c;
        int          lat;
        logic [31:0] r;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        c = cyc;
        op = o; a = x; b = y; start = 1'b1;
        r   = ref_result(o, x, y);
        lat = ref_latency(o, x, y);
        sb.push_back('{res: r, at: c + lat});
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        check("busy_first", busy, 1);
        if (lat > 1) begin
            check("result_hold", result, prev_res);
            repeat (lat - 1) @(posedge clk);
            #1;
            check("busy_last", busy, 1);
        end
        prev_res = r;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got result %h at cycle %0d want no pulse", result, cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("valid_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin : driver
        int          c;
        logic [31:0] pick [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
        logic [31:0] x;
        logic [31:0] y;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_result", result, 0);
        reset = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd5, 32'd100, 32'd7, 0);
        issue(3'd7, 32'd100, 32'd7, 0);
        issue(3'd5, 32'd5, 32'd0, 0);
        issue(3'd6, 32'd5, 32'd0, 0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Flush mid-divide with an ignored start while busy, then restart immediately.
        @(posedge clk);
        #1;
        c = cyc;
        op = 3'd4; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk); #1;
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("flush_cycle", cyc, c + 10);
        flush = 1'b1;
        check("busy_before_flush", busy, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        check("busy_after_flush", busy, 0);
        check("valid_after_flush", valid, 0);
        issue(3'd5, 32'd12345, 32'd10, 1);

        // Reset during a multiply aborts it and clears the result.
        @(posedge clk);
        #1;
        op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_mid_busy", busy, 0);
        check("reset_mid_valid", valid, 0);
        check("reset_mid_result", result, 0);
        prev_res = '0;
        issue(3'd0, 32'd3, 32'd5, 1);

        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(8, 28);
            issue(3'($urandom), x, y, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
